// File: rtl/six_digit_subtractor_seq.sv
// Bit-serial two's-complement subtractor: Diff = D1 - D2, one bit per clock, LSB first.
// Optional `SDS_SATURATE_EN clamps Diff on signed overflow instead of wrapping.
module six_digit_subtractor_seq #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             carry_q;
  logic [2:0]       cnt_q;

  logic             sum_bit, carry_out, ovf_bit, last_bit;
  logic [WIDTH-1:0] full_res, final_diff;

  // One full-adder cell; subtraction works as D1 + ~D2 + 1 with carry seeded to 1.
  always_comb begin
    sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    carry_out = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    full_res  = {sum_bit, res_q[WIDTH-1:1]};
    ovf_bit   = carry_q ^ carry_out;
    last_bit  = (cnt_q == 3'(WIDTH-1));
  end

`ifdef SDS_SATURATE_EN
  // On the final edge a_q[0] holds the sign of D1, which picks the clamp direction.
  always_comb begin
    final_diff = full_res;
    if (ovf_bit)
      final_diff = a_q[0] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign final_diff = full_res;
`endif

  // NOTE: datapath registers are reset too so a mid-run abort leaves no stale
  // partial result visible; all sequential state uses non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Diff    <= '0;
      Bout    <= 1'b0;
      Ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= D1;
            b_q     <= ~D2;
            carry_q <= 1'b1;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= full_res;
          carry_q <= carry_out;
          cnt_q   <= cnt_q + 3'd1;
          if (last_bit) begin
            Diff    <= final_diff;
            Bout    <= ~carry_out;
            Ovf     <= ovf_bit;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_six_digit_subtractor_seq.sv
// Scoreboard bench for six_digit_subtractor_seq: integer reference model, directed
// corner cases, sequencing (ignored start, mid-run reset, back-to-back) and random ops.
module tb_six_digit_subtractor_seq;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] D1, D2;
  logic         busy, done, Bout, Ovf;
  logic [W-1:0] Diff;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  exp_t         sb[$];
  logic [W+1:0] held;
  int           tests = 0;
  int           fails = 0;

  six_digit_subtractor_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .D1   (D1),
    .D2   (D2),
    .busy (busy),
    .done (done),
    .Diff (Diff),
    .Bout (Bout),
    .Ovf  (Ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: true integer difference, then range/borrow rules applied directly.
  function automatic exp_t model(input logic [W-1:0] d1, input logic [W-1:0] d2);
    exp_t e;
    int   sa, sb_v, diff, res;
    sa     = int'($signed(d1));
    sb_v   = int'($signed(d2));
    diff   = sa - sb_v;
    e.ovf  = (diff > (2**(W-1) - 1)) || (diff < -(2**(W-1)));
    e.bout = (d1 < d2);
    res    = diff;
`ifdef SDS_SATURATE_EN
    if (e.ovf) res = (diff > 0) ? (2**(W-1) - 1) : -(2**(W-1));
`endif
    e.diff = res[W-1:0];
    return e;
  endfunction

  // Monitor: pops on every done pulse; checks result registers hold while busy.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("diff", 32'(Diff), 32'(e.diff));
          check("bout", 32'(Bout), 32'(e.bout));
          check("ovf",  32'(Ovf),  32'(e.ovf));
          held = {e.diff, e.bout, e.ovf};
        end
      end else if (busy) begin
        check("hold_during_run", 32'({Diff, Bout, Ovf}), 32'(held));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issue one op, scramble operands after acceptance, check busy length and done latency.
  task automatic timed_op(input logic [W-1:0] d1, input logic [W-1:0] d2);
    int k = 0;
    int busy_cnt = 0;
    wait_idle();
    start = 1'b1;
    D1    = d1;
    D2    = d2;
    sb.push_back(model(d1, d2));
    @(posedge clk);
    #1;
    start = 1'b0;
    D1    = W'($urandom);
    D2    = W'($urandom);
    do begin
      @(negedge clk);
      k++;
      if (busy) busy_cnt++;
    end while (!done && k < 20);
    check("done_latency", 32'(k), 32'(W + 1));
    check("busy_cycles", 32'(busy_cnt), 32'(W));
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 30);
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    D1    = '0;
    D2    = '0;
    held  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_outs", 32'({Diff, Bout, Ovf}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed corner cases
    timed_op(6'b000010, 6'b000010);
    timed_op(6'b111001, 6'b000010);
    timed_op(6'b000010, 6'b000111);
    timed_op(6'b011111, 6'b111111);
    timed_op(6'b100000, 6'b000001);

    // Reset during a run: outputs clear immediately, no done afterwards
    wait_idle();
    start = 1'b1;
    D1    = 6'b000111;
    D2    = 6'b000001;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_outs", 32'({Diff, Bout, Ovf}), 32'd0);
    sb.delete();
    held = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Start pulsed while busy is ignored
    start = 1'b1;
    D1    = 6'b000010;
    D2    = 6'b000010;
    sb.push_back(model(6'b000010, 6'b000010));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    D1    = 6'b000101;
    D2    = 6'b111101;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();

    // Back-to-back: start presented in the done cycle
    timed_op(6'b010101, 6'b001010);
    timed_op(6'b110000, 6'b011000);

    // Random ops with random idle gaps (gap 0 exercises continuous start)
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      timed_op(W'($urandom), W'($urandom));
    end

    repeat (10) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/six_digit_subtractor_seq.md
Name: six_digit_subtractor_seq

Overview:
Bit-serial 6-bit two's-complement subtractor computing Diff = D1 - D2. It is the inverse-direction companion of the combinational six_digit_adder. It processes one bit per clock, LSB first, as D1 + ~D2 + 1 through a single full-adder cell, under a start/busy/done handshake. It sits beside the adder in the arithmetic datapath, where area is traded for latency.

Parameters:
WIDTH, 6, operand and result width in bits; the 3-bit counter supports WIDTH up to 8.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
D1  input  WIDTH  minuend, two's complement; captured on the accepting edge
D2  input  WIDTH  subtrahend, two's complement; captured on the accepting edge
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse: Diff, Bout and Ovf are valid
Diff  output  WIDTH  result D1 - D2, modulo 2^WIDTH
Bout  output  1  unsigned borrow: 1 iff D1 < D2 as unsigned (inverted final carry)
Ovf  output  1  signed overflow: 1 iff the true result lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]

Behaviour:
- Reset: rst_n low asynchronously forces the following, regardless of state, including mid-operation:
  - state=IDLE; busy=0, done=0, Diff=0, Bout=0, Ovf=0.
  - Internal shift registers cleared, carry cleared, bit counter=0.
- FSM with two states, IDLE and RUN.
- IDLE to RUN on the edge where start=1 (edge E0):
  - Capture A<=D1 and B<=~D2.
  - Set carry<=1 and cnt<=0; busy<=1.
- RUN, each edge:
  - Sum bit s = A[0]^B[0]^carry.
  - carry <= majority(A[0], B[0], carry).
  - A and B shift right by one; s shifts into the MSB of the result register.
  - cnt increments.
- Final RUN edge (edge E_WIDTH, i.e. E6 at default):
  - Load Diff from the result register including the last bit.
  - Bout <= ~carry_out of the MSB stage.
  - Ovf <= carry_in(MSB) ^ carry_out(MSB).
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: start accepted at E0; results valid and done high after E6; done drops after E7.
- Diff, Bout and Ovf hold their values until the next completion or reset. They do not change during RUN.
- start while busy: ignored; captured operands are unaffected.
- start high in the cycle done is high: state is already IDLE, so it is accepted at that edge, giving back-to-back operation with one idle-free gap.
- Operands D1/D2 may change freely after E0.
- start held high continuously: a new operation every WIDTH+1 cycles.

Optional Feature:
Macro SDS_SATURATE_EN.
- Defined: when Ovf=1 at completion, Diff is clamped instead of wrapped. Ovf and Bout are still reported unchanged.
  - Positive overflow (D1 non-negative) gives 2^(WIDTH-1)-1 (011111).
  - Negative overflow gives -2^(WIDTH-1) (100000).
- Undefined: Diff is the wrapped modulo-2^WIDTH result. No clamp logic is synthesised.

Test Plan:
- Reset, then D1=000010 (2), D2=000010 (2), start one cycle -> busy high 6 cycles; done pulse after E6 with Diff=000000, Bout=0, Ovf=0.
- D1=111001 (-7), D2=000010 (2) -> Diff=110111 (-9), Bout=0, Ovf=0.
- D1=000010 (2), D2=000111 (7) -> Diff=111011 (-5), Bout=1, Ovf=0.
- D1=011111 (31), D2=111111 (-1) -> Ovf=1, Bout=1. Diff=100000 without SDS_SATURATE_EN; Diff=011111 with it.
- D1=100000 (-32), D2=000001 (1) -> Ovf=1, Bout=0. Diff=011111 without the macro; Diff=100000 with it.
- Sequencing cases:
  - Start 2-2, pulse start again at cycle 3 with other operands -> ignored; result is 0.
  - Assert rst_n=0 at cycle 4 of a run -> all outputs 0 immediately; no done pulse.
  - Start asserted during the done cycle -> next done exactly 7 cycles later.
